arb_out_buffer: RTL
===================

ARB_OUT_BUFFER -- requirements
Module: arb_out_buffer

Interface
REQ-001 Parameter DEPTH, default 16: internal buffer depth in 32-bit words, power of two, 4..256.
REQ-002 Parameter MARGIN, default 2: free-slot margin; READY_OUT is withdrawn when free slots <= MARGIN.
REQ-003 BUS_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 BUS_RST  input  1  reset, asynchronous, active-high.
REQ-005 ENABLE  input  1  level; 1 = accept and stream, 0 = stop accepting and drain.
REQ-006 ARB_WRITE_OUT  input  1  write strobe from the arbiter, one word per high cycle.
REQ-007 ARB_DATA_OUT  input  32  arbiter data word, valid when ARB_WRITE_OUT=1.
REQ-008 ARB_READY_OUT  output  1  ready indication to the arbiter.
REQ-009 FIFO_FULL  input  1  downstream FIFO full; no write may be issued while high.
REQ-010 FIFO_NEAR_FULL  input  1  downstream FIFO near full.
REQ-011 FIFO_WRITE  output  1  write strobe to the downstream FIFO, registered.
REQ-012 FIFO_DATA  output  32  data to the downstream FIFO, registered, valid when FIFO_WRITE=1.
REQ-013 WORD_CNT  output  32  words delivered downstream, wrapping.
REQ-014 LOST_CNT  output  8  words dropped at the input, saturating at 255.
REQ-015 FILL  output  $clog2(DEPTH)+1  current buffer occupancy.
REQ-016 STATE  output  2  FSM state: IDLE=0, RUN=1, DRAIN=2.

Function
REQ-017 FSM: IDLE->RUN when ENABLE=1; RUN->DRAIN when ENABLE=0; DRAIN->IDLE when FILL=0 and FIFO_WRITE=0; DRAIN->RUN when ENABLE=1 again.
REQ-018 ARB_READY_OUT is registered: 1 only in RUN, with (DEPTH-FILL) > MARGIN and FIFO_NEAR_FULL=0 sampled at the previous edge.
REQ-019 Input acceptance: ARB_WRITE_OUT=1 in RUN with FILL<DEPTH pushes ARB_DATA_OUT; this is independent of ARB_READY_OUT, so the MARGIN slots absorb in-flight words.
REQ-020 Drop: ARB_WRITE_OUT=1 in IDLE or DRAIN, or with FILL=DEPTH, discards the word and increments LOST_CNT; the count saturates at 255.
REQ-021 Pop: at an edge where FILL>0 and FIFO_FULL=0, in RUN or DRAIN, the head word loads FIFO_DATA, FIFO_WRITE=1 for that cycle, and WORD_CNT increments; otherwise FIFO_WRITE=0 and FIFO_DATA holds its value.
REQ-022 In IDLE, no pops occur; buffer contents are retained.
REQ-023 Latency: a word pushed at edge k appears with FIFO_WRITE=1 after edge k+1 at the earliest; there is no push-to-output bypass.
REQ-024 Simultaneous push and pop in one cycle: both execute and FILL is unchanged; at FILL=DEPTH the push is still dropped, because pop-before-push is not credited.
REQ-025 Ordering is strict FIFO; no reordering and no duplication.
REQ-026 FILL = pushes - pops and never exceeds DEPTH; the pointers wrap modulo DEPTH.
REQ-027 WORD_CNT wraps from 0xFFFFFFFF to 0.
REQ-028 FIFO_FULL rising mid-stream stalls pops from the next edge; no word is lost or repeated.

Reset
REQ-029 BUS_RST=1 immediately forces STATE=IDLE, ARB_READY_OUT=0, FIFO_WRITE=0, FIFO_DATA=0, WORD_CNT=0, LOST_CNT=0, FILL=0, and pointers=0.
REQ-030 Reset asserted mid-stream discards all buffered words without counting them as lost.
REQ-031 After reset is released, the first state change happens no earlier than the first rising edge at which ENABLE=1 is sampled.

Verification
REQ-032 Pass-through:
- Stimulus: ENABLE=1, push 0x00000001..0x00000005 on consecutive cycles, FIFO_FULL=0.
- Response: FIFO_DATA 1..5 on consecutive FIFO_WRITE cycles, first write one edge after the first push, WORD_CNT=5, LOST_CNT=0.
REQ-033 Backpressure:
- Stimulus: FIFO_FULL=1, push 20 words with DEPTH=16.
- Response: ARB_READY_OUT=0 once FILL>=14, FILL=16, LOST_CNT=4; after FIFO_FULL=0, exactly words 1..16 come out in order.
REQ-034 Drain:
- Stimulus: ENABLE=1, push 6 words with FIFO_FULL=1, then ENABLE=0, then FIFO_FULL=0.
- Response: STATE=DRAIN, 6 words out, then STATE=IDLE; a push during DRAIN sets LOST_CNT=1.
REQ-035 Simultaneous push and pop:
- Stimulus: FILL=16 with push and pop in the same cycle.
- Response: pushed word dropped (LOST_CNT+1), FILL=15.
REQ-036 Saturation and wrap:
- Stimulus: 300 drops in IDLE.
- Response: LOST_CNT=255.
- Stimulus: WORD_CNT preset via force to 0xFFFFFFFF, then one pop.
- Response: WORD_CNT=0.
REQ-037 Reset mid-operation:
- Stimulus: BUS_RST pulse with FILL=7 and FIFO_WRITE=1.
- Response: outputs take REQ-029 values without waiting for a clock edge, and no FIFO_WRITE occurs after release until new words are pushed.

Source files
------------

// File: rtl/arb_out_buffer.sv
// Output buffer between the bus arbiter and a downstream FIFO.
// Words pushed in RUN are streamed out in order; ENABLE low drains the buffer back to IDLE.
module arb_out_buffer #(
    parameter int DEPTH  = 16,
    parameter int MARGIN = 2
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     ENABLE,
    input  logic                     ARB_WRITE_OUT,
    input  logic [31:0]              ARB_DATA_OUT,
    output logic                     ARB_READY_OUT,
    input  logic                     FIFO_FULL,
    input  logic                     FIFO_NEAR_FULL,
    output logic                     FIFO_WRITE,
    output logic [31:0]              FIFO_DATA,
    output logic [31:0]              WORD_CNT,
    output logic [7:0]               LOST_CNT,
    output logic [$clog2(DEPTH):0]   FILL,
    output logic [1:0]               STATE
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - MARGIN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [31:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wrPtr;
    logic [AW-1:0]   r_rdPtr;
    logic [AW:0]     r_fill;
    logic            r_ready;
    logic            r_fifoWrite;
    logic [31:0]     r_fifoData;
    logic [31:0]     r_wordCnt;
    logic [7:0]      r_lostCnt;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_readyNext;

    // Pushes ignore ARB_READY_OUT on purpose: the margin slots soak up words already in flight.
    assign w_push      = (r_state == RUN) && ARB_WRITE_OUT && (r_fill < FULL_LEVEL);
    assign w_drop      = ARB_WRITE_OUT && !w_push;
    assign w_pop       = ((r_state == RUN) || (r_state == DRAIN)) && (r_fill != '0) && !FIFO_FULL;
    assign w_readyNext = (r_state == RUN) && (r_fill < READY_LIMIT) && !FIFO_NEAR_FULL;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (ENABLE) w_nextState = RUN;
            RUN:     if (!ENABLE) w_nextState = DRAIN;
            DRAIN: begin
                if (ENABLE)
                    w_nextState = RUN;
                else if ((r_fill == '0) && !r_fifoWrite)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Storage array carries no reset; validity is tracked entirely by the pointers and fill.
    always_ff @(posedge BUS_CLK) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= ARB_DATA_OUT;
        end
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fill      <= '0;
            r_ready     <= 1'b0;
            r_fifoWrite <= 1'b0;
            r_fifoData  <= '0;
            r_wordCnt   <= '0;
            r_lostCnt   <= '0;
        end else begin
            r_ready     <= w_readyNext;
            r_fifoWrite <= w_pop;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr    <= r_rdPtr + 1'b1;
                r_fifoData <= r_mem[r_rdPtr];
                r_wordCnt  <= r_wordCnt + 32'd1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - 1'b1;
            end
            if (w_drop && (r_lostCnt != 8'hFF)) begin
                r_lostCnt <= r_lostCnt + 8'd1;
            end
        end
    end

    assign ARB_READY_OUT = r_ready;
    assign FIFO_WRITE    = r_fifoWrite;
    assign FIFO_DATA     = r_fifoData;
    assign WORD_CNT      = r_wordCnt;
    assign LOST_CNT      = r_lostCnt;
    assign FILL          = r_fill;
    assign STATE         = r_state;

endmodule
